hnf_pcrd_grant_sched: RTL and testbench
=======================================

# hnf_pcrd_grant_sched

Protocol-credit (P-credit) scheduler for the HN-F request path. It counts unreserved free MSHR entries and queues the {SrcID, PCrdType} of every RetryAck the HN-F sends. When an MSHR entry becomes available it issues PCrdGrant requests to the TXRSP arbiter. It also drives the retry-enable that the RXREQ parse logic uses to decide whether a new AllowRetry=1 request consumes its L-credit or is retried.

## Interface
Parameters:
- MSHR_ENTRIES, 16: total MSHR entries; reset value of the available-entry counter.
- RETRY_Q_DEPTH, 8: retry-queue depth (power of 2).
- SRCID_WIDTH, 11: CHI SrcID width.
- PCRDTYPE_WIDTH, 4: CHI PCrdType width.

Ports (reset rst, asynchronous, active-high; clock clk):
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- retry_push_s1  in  1  RetryAck won TXRSP arbitration this cycle.
- retry_srcid_s1  in  SRCID_WIDTH  target of that RetryAck.
- retry_pcrdtype_s1  in  PCRDTYPE_WIDTH  PCrdType carried by that RetryAck.
- mshr_alloc_s0  in  1  AllowRetry=1 request allocated an unreserved entry.
- mshr_release  in  1  one MSHR entry freed.
- pcrdgnt_valid  out  1  PCrdGrant pending toward TXRSP.
- pcrdgnt_srcid  out  SRCID_WIDTH  grant target (queue head).
- pcrdgnt_pcrdtype  out  PCRDTYPE_WIDTH  grant type (queue head).
- pcrdgnt_won  in  1  TXRSP accepted the grant this cycle.
- rxreq_retry_enable_s0  out  1  new AllowRetry=1 requests must be retried.
- avail_cnt  out  clog2(MSHR_ENTRIES+1)  unreserved free entries (debug/perf).
- err_sticky  out  2  bit0 retry-queue overflow, bit1 counter over/underflow.

## Operation
- Retry queue: circular FIFO of {srcid, pcrdtype}. Write and read pointers are clog2(DEPTH)+1 bits wide, with a wrap bit for the full/empty test.
  - Push on retry_push_s1.
  - Pop on pcrdgnt_won.
- Push while full and no pop in the same cycle: push dropped, err_sticky[0] set. Push while full with a pop in the same cycle is legal and keeps the queue full.
- Available counter: avail_nxt = avail_cnt + mshr_release - mshr_alloc_s0 - pcrdgnt_won. Computed one bit wider than the counter, then checked:
  - Result below 0 or above MSHR_ENTRIES: counter holds its value, err_sticky[1] set.
  - A granted entry stays reserved until the AllowRetry=0 request arrives; that request does not pulse mshr_alloc_s0.
- Grant: pcrdgnt_valid = queue not empty AND avail_cnt != 0. srcid/pcrdtype are the head entry. Valid is held with stable payload until pcrdgnt_won.
- pcrdgnt_won while pcrdgnt_valid=0 is illegal: ignored, err_sticky[1] set.
- Retry enable: rxreq_retry_enable_s0 = (avail_cnt == 0) OR queue not empty. Queued retriers therefore always win over new requests, which prevents starvation.
- All outputs are decoded from registered state only; there is no input-to-output combinational path.
- err_sticky clears only on reset.

## Timing
- Reset values:
  - pcrdgnt_valid 0, pcrdgnt_srcid 0, pcrdgnt_pcrdtype 0.
  - avail_cnt = MSHR_ENTRIES, rxreq_retry_enable_s0 0.
  - err_sticky 0, queue empty.
- Retry push to pcrdgnt_valid: 1 cycle, when avail_cnt != 0 at that edge.
- Release with a non-empty queue and avail_cnt=0: pcrdgnt_valid rises 1 cycle after the release.
- Won in cycle N: the next head (or deassertion) is visible in N+1. Back-to-back grants, one per cycle, are supported.
- Simultaneous events:
  - release+alloc: net 0.
  - release+won: net 0.
  - push+pop on an empty queue is impossible (valid requires non-empty).
- Asserting rst mid-grant drops the queue and the pending grant immediately (asynchronous). The counter returns to MSHR_ENTRIES.

## Test plan
- Reset, idle: avail_cnt=16, pcrdgnt_valid=0, retry_enable=0. 16 alloc pulses -> avail_cnt=0 and retry_enable=1 in the cycle after the 16th.
- With avail=0, push {srcid=0x005, type=1} -> valid stays 0. One mshr_release -> next cycle valid=1, srcid=0x005, type=1. Won -> avail stays 0, valid=0, retry_enable=1.
- Push 3 entries (0x001, 0x002, 0x003) with avail=4, won held high every cycle -> grants in order on 3 consecutive cycles, avail=1, queue empty, retry_enable=0.
- Fill the queue (8 pushes), then a 9th push with no won -> err_sticky=01, queue contents unchanged. Push together with won while full -> no error, count stays 8.
- Release with avail_cnt=16 -> err_sticky[1]=1, avail stays 16. Alloc+release in the same cycle at avail=5 -> avail stays 5.
- Assert rst while valid=1 with 4 queued -> valid=0 asynchronously. After deassert: avail=16, queue empty, err_sticky=0.

Source files
------------

// File: rtl/hnf_pcrd_grant_sched.sv
// rtl/hnf_pcrd_grant_sched.sv - HN-F P-credit grant scheduler: retry queue, free-entry counter, grant issue
module hnf_pcrd_grant_sched #(
    parameter int MSHR_ENTRIES   = 16,
    parameter int RETRY_Q_DEPTH  = 8,
    parameter int SRCID_WIDTH    = 11,
    parameter int PCRDTYPE_WIDTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 retry_push_s1,
    input  logic [SRCID_WIDTH-1:0]               retry_srcid_s1,
    input  logic [PCRDTYPE_WIDTH-1:0]            retry_pcrdtype_s1,
    input  logic                                 mshr_alloc_s0,
    input  logic                                 mshr_release,
    output logic                                 pcrdgnt_valid,
    output logic [SRCID_WIDTH-1:0]               pcrdgnt_srcid,
    output logic [PCRDTYPE_WIDTH-1:0]            pcrdgnt_pcrdtype,
    input  logic                                 pcrdgnt_won,
    output logic                                 rxreq_retry_enable_s0,
    output logic [$clog2(MSHR_ENTRIES+1)-1:0]    avail_cnt,
    output logic [1:0]                           err_sticky
);
    localparam int CW = $clog2(MSHR_ENTRIES + 1);
    localparam int PW = $clog2(RETRY_Q_DEPTH);
    localparam int EW = SRCID_WIDTH + PCRDTYPE_WIDTH;
    localparam logic [CW-1:0]        AVAIL_RST = CW'(MSHR_ENTRIES);
    localparam logic signed [CW:0]   AVAIL_MAX = (CW+1)'(MSHR_ENTRIES);

    logic [EW-1:0]  mem_q [RETRY_Q_DEPTH];
    logic [EW-1:0]  mem_d [RETRY_Q_DEPTH];
    logic [PW:0]    wr_ptr_q, wr_ptr_d;
    logic [PW:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  avail_q, avail_d;
    logic [1:0]     err_q, err_d;

    logic              q_empty;
    logic              q_full;
    logic              pop;
    logic              push_ok;
    logic [EW-1:0]     head;
    logic signed [CW:0] avail_nxt;

    // Outputs decode registered state only.
    always_comb begin
        q_empty = (wr_ptr_q == rd_ptr_q);
        q_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                  (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
        head    = mem_q[rd_ptr_q[PW-1:0]];

        pcrdgnt_valid         = !q_empty && (avail_q != '0);
        pcrdgnt_srcid         = q_empty ? '0 : head[EW-1:PCRDTYPE_WIDTH];
        pcrdgnt_pcrdtype      = q_empty ? '0 : head[PCRDTYPE_WIDTH-1:0];
        rxreq_retry_enable_s0 = (avail_q == '0) || !q_empty;
        avail_cnt             = avail_q;
        err_sticky            = err_q;
    end

    always_comb begin
        pop     = pcrdgnt_won && pcrdgnt_valid;
        // A full queue can still accept a push when the head leaves in the same cycle.
        push_ok = retry_push_s1 && (!q_full || pop);

        mem_d = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q[PW-1:0]] = {retry_srcid_s1, retry_pcrdtype_s1};
        end
        wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, push_ok};
        rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, pop};

        avail_nxt = $signed({1'b0, avail_q})
                  + $signed({{CW{1'b0}}, mshr_release})
                  - $signed({{CW{1'b0}}, mshr_alloc_s0})
                  - $signed({{CW{1'b0}}, pop});

        err_d   = err_q;
        avail_d = avail_q;
        if (retry_push_s1 && !push_ok) begin
            err_d[0] = 1'b1;
        end
        if (pcrdgnt_won && !pcrdgnt_valid) begin
            err_d[1] = 1'b1;
        end
        if (avail_nxt[CW] || (avail_nxt > AVAIL_MAX)) begin
            err_d[1] = 1'b1;
        end else begin
            avail_d = avail_nxt[CW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RETRY_Q_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            avail_q  <= AVAIL_RST;
            err_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            avail_q  <= avail_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_hnf_pcrd_grant_sched.sv
// tb/tb_hnf_pcrd_grant_sched.sv - scoreboard bench for hnf_pcrd_grant_sched
module tb_hnf_pcrd_grant_sched;
    localparam int MSHR  = 16;
    localparam int DEPTH = 8;
    localparam int SW    = 11;
    localparam int TW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          retry_push_s1 = 1'b0;
    logic [SW-1:0] retry_srcid_s1 = '0;
    logic [TW-1:0] retry_pcrdtype_s1 = '0;
    logic          mshr_alloc_s0 = 1'b0;
    logic          mshr_release = 1'b0;
    logic          pcrdgnt_valid;
    logic [SW-1:0] pcrdgnt_srcid;
    logic [TW-1:0] pcrdgnt_pcrdtype;
    logic          pcrdgnt_won = 1'b0;
    logic          rxreq_retry_enable_s0;
    logic [4:0]    avail_cnt;
    logic [1:0]    err_sticky;

    hnf_pcrd_grant_sched #(
        .MSHR_ENTRIES(MSHR), .RETRY_Q_DEPTH(DEPTH),
        .SRCID_WIDTH(SW), .PCRDTYPE_WIDTH(TW)
    ) dut (
        .clk(clk), .rst(rst),
        .retry_push_s1(retry_push_s1), .retry_srcid_s1(retry_srcid_s1),
        .retry_pcrdtype_s1(retry_pcrdtype_s1),
        .mshr_alloc_s0(mshr_alloc_s0), .mshr_release(mshr_release),
        .pcrdgnt_valid(pcrdgnt_valid), .pcrdgnt_srcid(pcrdgnt_srcid),
        .pcrdgnt_pcrdtype(pcrdgnt_pcrdtype), .pcrdgnt_won(pcrdgnt_won),
        .rxreq_retry_enable_s0(rxreq_retry_enable_s0),
        .avail_cnt(avail_cnt), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    typedef logic [SW+TW-1:0] ent_t;

    // Reference model: pending retriers, free-entry count, sticky errors.
    ent_t     mq[$];
    ent_t     exp_q[$];
    int       m_avail = MSHR;
    logic [1:0] m_err = 2'b00;
    bit       mon_en = 1'b0;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_valid();
        return (mq.size() != 0) && (m_avail != 0);
    endfunction

    // Called at posedge+1; applies one cycle of inputs and advances the model after the edge.
    task automatic drive(input bit push, input logic [SW-1:0] sid, input logic [TW-1:0] pt,
                         input bit alloc, input bit rel, input bit won);
        bit   pop, acc;
        int   n, nav;
        logic [1:0] nerr;
        retry_push_s1     = push;
        retry_srcid_s1    = sid;
        retry_pcrdtype_s1 = pt;
        mshr_alloc_s0     = alloc;
        mshr_release      = rel;
        pcrdgnt_won       = won;
        nerr = m_err;
        pop  = won && m_valid();
        if (won && !m_valid()) nerr[1] = 1'b1;
        acc = 1'b0;
        if (push) begin
            if (mq.size() - int'(pop) >= DEPTH) nerr[0] = 1'b1;
            else acc = 1'b1;
        end
        n   = m_avail + int'(rel) - int'(alloc) - int'(pop);
        nav = m_avail;
        if (n < 0 || n > MSHR) nerr[1] = 1'b1;
        else nav = n;
        @(posedge clk);
        #1;
        if (pop) void'(mq.pop_front());
        if (acc) begin
            mq.push_back({sid, pt});
            exp_q.push_back({sid, pt});
        end
        m_avail = nav;
        m_err   = nerr;
        retry_push_s1 = 1'b0;
        mshr_alloc_s0 = 1'b0;
        mshr_release  = 1'b0;
        pcrdgnt_won   = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: state outputs against the model, accepted grants against the scoreboard.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            chk("avail_cnt", 32'(avail_cnt), 32'(m_avail));
            chk("pcrdgnt_valid", 32'(pcrdgnt_valid), 32'(m_valid()));
            chk("retry_enable", 32'(rxreq_retry_enable_s0),
                32'((m_avail == 0) || (mq.size() != 0)));
            chk("err_sticky", 32'(err_sticky), 32'(m_err));
            if (pcrdgnt_valid && pcrdgnt_won) begin
                if (exp_q.size() == 0) begin
                    chk("grant_unexpected", 32'(1), 32'(0));
                end else begin
                    ent_t e;
                    e = exp_q.pop_front();
                    chk("grant_srcid", 32'(pcrdgnt_srcid), 32'(e[SW+TW-1:TW]));
                    chk("grant_type", 32'(pcrdgnt_pcrdtype), 32'(e[TW-1:0]));
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(pcrdgnt_valid), 32'(0));
        chk("rst_srcid", 32'(pcrdgnt_srcid), 32'(0));
        chk("rst_type", 32'(pcrdgnt_pcrdtype), 32'(0));
        chk("rst_avail", 32'(avail_cnt), 32'(MSHR));
        chk("rst_retry_en", 32'(rxreq_retry_enable_s0), 32'(0));
        chk("rst_err", 32'(err_sticky), 32'(0));
        rst = 1'b0;
        mon_en = 1'b1;
        idle();

        // Exhaust the free entries.
        for (int i = 0; i < MSHR; i++) drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        idle();

        // Retry held back until an entry frees.
        drive(1'b1, 11'h005, 4'h1, 1'b0, 1'b0, 1'b0);
        idle();
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        chk("first_grant_srcid", 32'(pcrdgnt_srcid), 32'h005);
        drive(1'b0, '0, '0, 1'b0, 1'b0, m_valid());
        idle();

        // Back-to-back grants with four free entries.
        for (int i = 0; i < 4; i++) drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 3; i++) drive(1'b1, SW'(i), TW'(i), 1'b0, 1'b0, m_valid());
        for (int i = 0; i < 4; i++) drive(1'b0, '0, '0, 1'b0, 1'b0, m_valid());
        chk("b2b_avail", 32'(avail_cnt), 32'(1));

        // Overflow, then push-with-pop while full.
        for (int i = 0; i < DEPTH; i++) drive(1'b1, SW'(8'h40 + i), TW'(i), 1'b0, 1'b0, 1'b0);
        drive(1'b1, 11'h7ff, 4'hf, 1'b0, 1'b0, 1'b0);
        chk("overflow_err", 32'(err_sticky), 32'(1));
        drive(1'b1, 11'h055, 4'h5, 1'b0, 1'b1, 1'b1);
        chk("full_keep_count", 32'(mq.size()), 32'(DEPTH));
        for (int i = 0; i < 60 && mq.size() != 0; i++)
            drive(1'b0, '0, '0, 1'b0, m_avail < 3, m_valid());

        // Counter overflow and net-zero alloc+release.
        for (int i = 0; i < 40 && m_avail < MSHR; i++) drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        chk("ovf_avail", 32'(avail_cnt), 32'(MSHR));
        chk("ovf_err", 32'(err_sticky[1]), 32'(1));
        for (int i = 0; i < MSHR - 5; i++) drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
        chk("net_zero_avail", 32'(avail_cnt), 32'(5));

        // Asynchronous reset mid-grant.
        for (int i = 0; i < 4; i++) drive(1'b1, SW'(8'h20 + i), TW'(i), 1'b0, 1'b0, 1'b0);
        chk("pre_rst_valid", 32'(pcrdgnt_valid), 32'(1));
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(pcrdgnt_valid), 32'(0));
        mq.delete();
        exp_q.delete();
        m_avail = MSHR;
        m_err   = 2'b00;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("post_rst_avail", 32'(avail_cnt), 32'(MSHR));
        chk("post_rst_err", 32'(err_sticky), 32'(0));
        chk("post_rst_retry_en", 32'(rxreq_retry_enable_s0), 32'(0));

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit won;
            won = m_valid() ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 199) == 0);
            drive($urandom_range(0, 2) == 0, SW'($urandom), TW'($urandom),
                  (m_avail > 0) && ($urandom_range(0, 3) == 0),
                  $urandom_range(0, 3) == 0, won);
        end
        mon_en = 1'b0;
        chk("scoreboard_depth", 32'(exp_q.size()), 32'(mq.size()));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
